// File: rtl/opr1_sequencer.sv
// PDP-8 Group 1 operate sequencer: walks CLR -> CMP -> INC -> ROT over a latched AC/Link,
// skipping disabled phases, and hands the rotate phase to the external shared rotater.
module opr1_sequencer #(
   parameter int WIDTH = 12
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             start_i,
   input  logic [11:0]      ir_i,
   input  logic [WIDTH-1:0] ac_in_i,
   input  logic             l_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             ill_o,
   output logic [WIDTH-1:0] ac_out_o,
   output logic             l_out_o,
   output logic [2:0]       rot_op_o,
   output logic [WIDTH-1:0] rot_ai_o,
   output logic             rot_li_o,
   output logic             rot_oe_o,
   input  logic [WIDTH-1:0] rot_ao_i,
   input  logic             rot_lo_i
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CLR  = 3'd1,
      S_CMP  = 3'd2,
      S_INC  = 3'd3,
      S_ROT  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [11:0]      ir_q;
   logic [WIDTH-1:0] ac_q, ac_d, ac_out_q;
   logic             l_q, l_d, l_out_q;

   logic [11:0]      ir_sel;
   logic             grp1, en_clr, en_cmp, en_inc, en_rot;
   state_t           after_clr, after_cmp, after_inc, after_idle;
   logic [WIDTH:0]   inc_sum;

   // In IDLE the phase plan comes from the incoming word; afterwards from the latched copy.
   assign ir_sel = (state_q == S_IDLE) ? ir_i : ir_q;
   assign grp1   = (ir_sel[11:8] == 4'b1110);
   assign en_clr = grp1 & (ir_sel[7] | ir_sel[6]);
   assign en_cmp = grp1 & (ir_sel[5] | ir_sel[4]);
   assign en_inc = grp1 & ir_sel[0];
   assign en_rot = grp1 & (|ir_sel[3:1]);

   assign after_inc  = en_rot ? S_ROT : S_DONE;
   assign after_cmp  = en_inc ? S_INC : after_inc;
   assign after_clr  = en_cmp ? S_CMP : after_cmp;
   assign after_idle = en_clr ? S_CLR : after_clr;

   assign inc_sum = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = after_idle;
         S_CLR:   state_d = after_clr;
         S_CMP:   state_d = after_cmp;
         S_INC:   state_d = after_inc;
         S_ROT:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Working AC/Link next value for whichever phase is active this cycle.
   always_comb begin
      ac_d = ac_q;
      l_d  = l_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               ac_d = ac_in_i;
               l_d  = l_in_i;
            end
         end
         S_CLR: begin
            if (ir_q[7]) ac_d = '0;
            if (ir_q[6]) l_d  = 1'b0;
         end
         S_CMP: begin
            if (ir_q[5]) ac_d = ~ac_q;
            if (ir_q[4]) l_d  = ~l_q;
         end
         S_INC: begin
            ac_d = inc_sum[WIDTH-1:0];
            l_d  = l_q ^ inc_sum[WIDTH];
         end
         S_ROT: begin
            ac_d = rot_ao_i;
            l_d  = rot_lo_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         ir_q     <= '0;
         ac_q     <= '0;
         l_q      <= 1'b0;
         ac_out_q <= '0;
         l_out_q  <= 1'b0;
      end else begin
         ac_q <= ac_d;
         l_q  <= l_d;
         if (state_q == S_IDLE && start_i) ir_q <= ir_i;
         // Result registers load on the edge that enters DONE so they are valid with the pulse.
         if (state_d == S_DONE) begin
            ac_out_q <= ac_d;
            l_out_q  <= l_d;
         end
      end
   end

   always_comb begin
      busy_o   = 1'b0;
      done_o   = 1'b0;
      ill_o    = 1'b0;
      rot_oe_o = 1'b0;
      rot_op_o = 3'b000;
      rot_ai_o = '0;
      rot_li_o = 1'b0;
      case (state_q)
         S_CLR, S_CMP, S_INC: busy_o = 1'b1;
         S_ROT: begin
            busy_o   = 1'b1;
            rot_oe_o = 1'b1;
            rot_op_o = ir_q[3:1];
            rot_ai_o = ac_q;
            rot_li_o = l_q;
         end
         S_DONE: begin
            done_o = 1'b1;
            ill_o  = (ir_q[11:8] != 4'b1110);
         end
         default: ;
      endcase
   end

   assign ac_out_o = ac_out_q;
   assign l_out_o  = l_out_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Self-checking bench for opr1_sequencer: behavioural rotater, expected results queued at
// START and popped when DONE pulses.
module tb_opr1_sequencer;

   localparam int WIDTH = 12;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] ir = '0;
   logic [11:0] ac_in = '0;
   logic        l_in = 1'b0;
   logic        busy, done, ill, l_out, rot_li, rot_oe, rot_lo;
   logic [11:0] ac_out, rot_ai, rot_ao;
   logic [2:0]  rot_op;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [11:0] ac;
      logic        l;
      logic        ill;
      int          lat;
      logic [2:0]  op;
      int          rot_cnt;
   } exp_t;

   exp_t sb[$];

   opr1_sequencer #(.WIDTH(WIDTH)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .ir_i(ir),
      .ac_in_i(ac_in), .l_in_i(l_in), .busy_o(busy), .done_o(done), .ill_o(ill),
      .ac_out_o(ac_out), .l_out_o(l_out), .rot_op_o(rot_op), .rot_ai_o(rot_ai),
      .rot_li_o(rot_li), .rot_oe_o(rot_oe), .rot_ao_i(rot_ao), .rot_lo_i(rot_lo)
   );

   always #5 clk = ~clk;

   // v = {L, AC}
   function automatic logic [12:0] rotate(input logic [2:0] op, input logic [12:0] v);
      case (op)
         3'b100:  return {v[0], v[12:1]};
         3'b010:  return {v[11:0], v[12]};
         3'b101:  return {v[1:0], v[12:2]};
         3'b011:  return {v[10:0], v[12:11]};
         3'b001:  return {v[12], v[5:0], v[11:6]};
         default: return v;
      endcase
   endfunction

   assign {rot_lo, rot_ao} = rotate(rot_op, {rot_li, rot_ai});

   function automatic exp_t model(input logic [11:0] i_ir, input logic [11:0] i_ac, input logic i_l);
      exp_t e;
      logic [12:0] v;
      v = {i_l, i_ac};
      e.ill = 1'b0; e.lat = 1; e.op = 3'b000; e.rot_cnt = 0;
      if (i_ir[11:8] != 4'b1110) begin
         e.ill = 1'b1;
      end else begin
         if (i_ir[7] | i_ir[6]) begin
            e.lat++;
            if (i_ir[7]) v[11:0] = '0;
            if (i_ir[6]) v[12] = 1'b0;
         end
         if (i_ir[5] | i_ir[4]) begin
            e.lat++;
            if (i_ir[5]) v[11:0] = ~v[11:0];
            if (i_ir[4]) v[12] = ~v[12];
         end
         if (i_ir[0]) begin
            e.lat++;
            v = v + 13'd1;
         end
         if (i_ir[3:1] != 3'b000) begin
            e.lat++;
            e.op = i_ir[3:1];
            e.rot_cnt = 1;
            v = rotate(i_ir[3:1], v);
         end
      end
      e.l = v[12];
      e.ac = v[11:0];
      return e;
   endfunction

   task automatic run_op(input logic [11:0] i_ir, input logic [11:0] i_ac, input logic i_l,
                         input int extra_start_at, input string name);
      exp_t e;
      int cyc, oe_cnt;
      logic [2:0] op_seen;
      sb.push_back(model(i_ir, i_ac, i_l));
      @(negedge clk);
      ir = i_ir; ac_in = i_ac; l_in = i_l; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ir = 12'o0000; ac_in = i_ac ^ 12'o5252; l_in = ~i_l;
      cyc = 1; oe_cnt = 0; op_seen = 3'b000;
      while (!done && cyc < 20) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy cyc=%0d got=%b want=1", name, cyc, busy);
         end
         if (rot_oe === 1'b1) begin
            oe_cnt++;
            op_seen = rot_op;
         end
         start = (cyc == extra_start_at);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout got=no DONE want=DONE within 20 cycles", name);
         return;
      end
      checks++;
      if (cyc != e.lat) begin
         errors++;
         $display("FAIL %s latency got=%0d want=%0d", name, cyc, e.lat);
      end
      checks++;
      if (ac_out !== e.ac || l_out !== e.l) begin
         errors++;
         $display("FAIL %s result got=L%b AC%o want=L%b AC%o", name, l_out, ac_out, e.l, e.ac);
      end
      checks++;
      if (ill !== e.ill || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s ill/busy got=%b/%b want=%b/0", name, ill, busy, e.ill);
      end
      checks++;
      if (oe_cnt != e.rot_cnt || op_seen !== e.op) begin
         errors++;
         $display("FAIL %s rotater got=oe%0d op%b want=oe%0d op%b", name, oe_cnt, op_seen, e.rot_cnt, e.op);
      end
      $display("txn %s ir=%o ac=%o l=%b -> ac=%o l=%b ill=%b lat=%0d", name, i_ir, i_ac, i_l,
               ac_out, l_out, ill, cyc);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, ill, l_out, rot_oe, rot_li} !== 6'b0 || ac_out !== 12'o0 ||
          rot_op !== 3'b000 || rot_ai !== 12'o0) begin
         errors++;
         $display("FAIL reset outputs got=b%b d%b i%b ac%o l%b oe%b op%b ai%o li%b want=all zero",
                  busy, done, ill, ac_out, l_out, rot_oe, rot_op, rot_ai, rot_li);
      end
      reset_n = 1'b1;
      $display("txn reset released");
   endtask

   task automatic test_clr_cmp();
      run_op(12'o7340, 12'o1234, 1'b0, -1, "cla_cma");
   endtask

   task automatic test_inc();
      run_op(12'o7001, 12'o7777, 1'b0, -1, "iac_l0");
      run_op(12'o7001, 12'o7777, 1'b1, -1, "iac_l1");
   endtask

   task automatic test_rotate();
      run_op(12'o7004, 12'o4000, 1'b0, -1, "ral");
      run_op(12'o7012, 12'o0001, 1'b0, -1, "rtr");
      run_op(12'o7002, 12'o0077, 1'b1, -1, "bsw");
      run_op(12'o7006, 12'o4001, 1'b0, -1, "rtl");
      run_op(12'o7014, 12'o1357, 1'b1, -1, "op110");
   endtask

   task automatic test_busy_start();
      run_op(12'o7321, 12'o5555, 1'b1, 2, "cla_cll_cml_iac");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL extra_done cyc=%0d got=%b want=0", i, done);
         end
      end
   endtask

   task automatic test_illegal();
      run_op(12'o5000, 12'o1234, 1'b1, -1, "illegal");
   endtask

   task automatic test_abort();
      @(negedge clk);
      ir = 12'o7240; ac_in = 12'o1234; l_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || rot_oe !== 1'b0) begin
         errors++;
         $display("FAIL abort_cmp_phase got=busy%b oe%b want=busy1 oe0", busy, rot_oe);
      end
      reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done, ill, l_out, rot_oe} !== 5'b0 || ac_out !== 12'o0) begin
         errors++;
         $display("FAIL abort_reset got=b%b d%b i%b ac%o l%b oe%b want=all zero",
                  busy, done, ill, ac_out, l_out, rot_oe);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle cyc=%0d got=d%b b%b want=d0 b0", i, done, busy);
         end
      end
      $display("txn abort ir=7240 reset during CMP");
   endtask

   task automatic test_back_to_back();
      logic [11:0] r_ir, r_ac;
      for (int i = 0; i < 10; i++) begin
         r_ir = {4'b1110, 8'($urandom)};
         r_ac = 12'($urandom);
         run_op(r_ir, r_ac, 1'($urandom), -1, "random");
      end
   endtask

   initial begin
      test_reset();
      test_clr_cmp();
      test_inc();
      test_rotate();
      test_busy_start();
      test_illegal();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=no finish want=finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
